// File: rtl/reg_access_arbiter.sv
// Two-port arbiter in front of the single register-file access port.
// Serialises port A (SPI decoder) and port B (PWM engine) accesses and rejects out-of-range addresses.
module reg_access_arbiter #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 8,
   parameter int NUM_REGS   = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              rf_read,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              addr_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RDRET} state_t;

   state_t            state;
   logic              last_b;
   logic              win_b_p0;
   logic              wr_p0;
   logic              err_p0;
   logic              pick_b;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_ok;

   // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
   endfunction

   always_comb begin
      pick_b = b_req;
      if (a_req && b_req)
         pick_b = (FIXED_PRIO != 0) ? 1'b0 : ~last_b;
      sel_write = pick_b ? b_write : a_write;
      sel_addr  = pick_b ? b_addr  : a_addr;
      sel_wdata = pick_b ? b_wdata : a_wdata;
      sel_ok    = in_range(sel_addr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         a_gnt    <= 1'b0;
         b_gnt    <= 1'b0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
         rf_read  <= 1'b0;
         rf_write <= 1'b0;
         rf_addr  <= '0;
         rf_wdata <= '0;
         addr_err <= 1'b0;
         busy     <= 1'b0;
      end else begin
         a_gnt    <= 1'b0;
         b_gnt    <= 1'b0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         rf_read  <= 1'b0;
         rf_write <= 1'b0;
         rf_addr  <= '0;
         rf_wdata <= '0;
         addr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  win_b_p0 <= pick_b;
                  wr_p0    <= sel_write;
                  err_p0   <= ~sel_ok;
                  last_b   <= pick_b;
                  a_gnt    <= ~pick_b;
                  b_gnt    <= pick_b;
                  if (sel_ok) begin
                     rf_write <= sel_write;
                     rf_read  <= ~sel_write;
                     rf_addr  <= sel_addr;
                     rf_wdata <= sel_wdata;
                  end else begin
                     addr_err <= 1'b1;
                  end
                  busy  <= 1'b1;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               busy  <= ~wr_p0;
               state <= wr_p0 ? IDLE : RDWAIT;
            end
            RDWAIT: begin
               // rf_rdata answers the strobe issued during ACCESS.
               if (win_b_p0) b_rdata <= err_p0 ? '0 : rf_rdata;
               else          a_rdata <= err_p0 ? '0 : rf_rdata;
               a_rvalid <= ~win_b_p0;
               b_rvalid <= win_b_p0;
               state    <= RDRET;
            end
            RDRET: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
